// File: rtl/axi_rd_arbiter_pkg.sv
// ============================================================================
// Module      : axi_rd_arbiter_pkg
// Description : Shared AXI width macros, read-arbiter FSM states and master
//               index type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    typedef logic mst_idx_t;

    function automatic mst_idx_t onehot_to_idx(input logic [1:0] onehot);
        return onehot[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// ============================================================================
// Module      : RR_ARB2
// Description : Two-requester round-robin arbiter with priority register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module RR_ARB2
    import axi_rd_arbiter_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  mst_idx_t   served,
    output logic [1:0] grant
);

    localparam mst_idx_t c_init = RR_INIT[0];

    mst_idx_t r_prio;

    // After a completed burst the other master holds priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= c_init;
        end else if (advance) begin
            r_prio <= ~served;
        end
    end

    always_comb begin
        if (&req) begin
            grant = r_prio ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Two-master AXI read arbiter, one outstanding burst at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic                      AXI_CLK_i,
    input  logic                      AXI_RST_i,

    input  logic [`AXI_ID_BITS-1:0]   M0_ARID_i,
    input  logic [`AXI_ADDR_BITS-1:0] M0_ARADDR_i,
    input  logic [`AXI_LEN_BITS-1:0]  M0_ARLEN_i,
    input  logic [`AXI_SIZE_BITS-1:0] M0_ARSIZE_i,
    input  logic [1:0]                M0_ARBURST_i,
    input  logic                      M0_ARVALID_i,
    output logic                      M0_ARREADY_o,
    output logic [`AXI_ID_BITS-1:0]   M0_RID_o,
    output logic [`AXI_DATA_BITS-1:0] M0_RDATA_o,
    output logic [1:0]                M0_RRESP_o,
    output logic                      M0_RLAST_o,
    output logic                      M0_RVALID_o,
    input  logic                      M0_RREADY_i,

    input  logic [`AXI_ID_BITS-1:0]   M1_ARID_i,
    input  logic [`AXI_ADDR_BITS-1:0] M1_ARADDR_i,
    input  logic [`AXI_LEN_BITS-1:0]  M1_ARLEN_i,
    input  logic [`AXI_SIZE_BITS-1:0] M1_ARSIZE_i,
    input  logic [1:0]                M1_ARBURST_i,
    input  logic                      M1_ARVALID_i,
    output logic                      M1_ARREADY_o,
    output logic [`AXI_ID_BITS-1:0]   M1_RID_o,
    output logic [`AXI_DATA_BITS-1:0] M1_RDATA_o,
    output logic [1:0]                M1_RRESP_o,
    output logic                      M1_RLAST_o,
    output logic                      M1_RVALID_o,
    input  logic                      M1_RREADY_i,

    output logic [`AXI_ID_BITS-1:0]   S_ARID_o,
    output logic [`AXI_ADDR_BITS-1:0] S_ARADDR_o,
    output logic [`AXI_LEN_BITS-1:0]  S_ARLEN_o,
    output logic [`AXI_SIZE_BITS-1:0] S_ARSIZE_o,
    output logic [1:0]                S_ARBURST_o,
    output logic                      S_ARVALID_o,
    input  logic                      S_ARREADY_i,

    input  logic [`AXI_ID_BITS-1:0]   S_RID_i,
    input  logic [`AXI_DATA_BITS-1:0] S_RDATA_i,
    input  logic [1:0]                S_RRESP_i,
    input  logic                      S_RLAST_i,
    input  logic                      S_RVALID_i,
    output logic                      S_RREADY_o,

    output logic [1:0]                GRANT_o
);

    arb_state_e r_state;
    logic [1:0] r_grant;
    logic [1:0] w_arb_grant;
    mst_idx_t   w_own;
    logic       w_in_addr;
    logic       w_in_data;
    logic       w_last_hs;

    assign w_own     = onehot_to_idx(r_grant);
    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);
    assign w_last_hs = w_in_data & S_RVALID_i & S_RREADY_o & S_RLAST_i;
    assign GRANT_o   = r_grant;

    RR_ARB2 #(
        .RR_INIT (RR_INIT)
    ) u_rr_arb2 (
        .clk     (AXI_CLK_i),
        .rst_n   (AXI_RST_i),
        .req     ({M1_ARVALID_i, M0_ARVALID_i}),
        .advance (w_last_hs),
        .served  (w_own),
        .grant   (w_arb_grant)
    );

    always_ff @(posedge AXI_CLK_i) begin
        if (!AXI_RST_i) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (M0_ARVALID_i | M1_ARVALID_i) begin
                        r_grant <= w_arb_grant;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (S_ARREADY_i) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_last_hs) begin
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Everything not owned by the granted master in the current phase is zero
    always_comb begin
        S_ARID_o     = '0;
        S_ARADDR_o   = '0;
        S_ARLEN_o    = '0;
        S_ARSIZE_o   = '0;
        S_ARBURST_o  = '0;
        S_ARVALID_o  = 1'b0;
        S_RREADY_o   = 1'b0;
        M0_ARREADY_o = 1'b0;
        M1_ARREADY_o = 1'b0;
        M0_RID_o     = '0;
        M0_RDATA_o   = '0;
        M0_RRESP_o   = '0;
        M0_RLAST_o   = 1'b0;
        M0_RVALID_o  = 1'b0;
        M1_RID_o     = '0;
        M1_RDATA_o   = '0;
        M1_RRESP_o   = '0;
        M1_RLAST_o   = 1'b0;
        M1_RVALID_o  = 1'b0;

        if (w_in_addr) begin
            S_ARVALID_o = 1'b1;
            if (w_own) begin
                S_ARID_o     = M1_ARID_i;
                S_ARADDR_o   = M1_ARADDR_i;
                S_ARLEN_o    = M1_ARLEN_i;
                S_ARSIZE_o   = M1_ARSIZE_i;
                S_ARBURST_o  = M1_ARBURST_i;
                M1_ARREADY_o = S_ARREADY_i;
            end else begin
                S_ARID_o     = M0_ARID_i;
                S_ARADDR_o   = M0_ARADDR_i;
                S_ARLEN_o    = M0_ARLEN_i;
                S_ARSIZE_o   = M0_ARSIZE_i;
                S_ARBURST_o  = M0_ARBURST_i;
                M0_ARREADY_o = S_ARREADY_i;
            end
        end

        // Read data follows the grant, never S_RID_i
        if (w_in_data) begin
            if (w_own) begin
                S_RREADY_o  = M1_RREADY_i;
                M1_RID_o    = S_RID_i;
                M1_RDATA_o  = S_RDATA_i;
                M1_RRESP_o  = S_RRESP_i;
                M1_RLAST_o  = S_RLAST_i;
                M1_RVALID_o = S_RVALID_i;
            end else begin
                S_RREADY_o  = M0_RREADY_i;
                M0_RID_o    = S_RID_i;
                M0_RDATA_o  = S_RDATA_i;
                M0_RRESP_o  = S_RRESP_i;
                M0_RLAST_o  = S_RLAST_i;
                M0_RVALID_o = S_RVALID_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed and randomized bench for axi_rd_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module tb_axi_rd_arbiter;

    localparam int IDW = `AXI_ID_BITS;
    localparam int AW  = `AXI_ADDR_BITS;
    localparam int LW  = `AXI_LEN_BITS;
    localparam int SW  = `AXI_SIZE_BITS;
    localparam int DW  = `AXI_DATA_BITS;
    localparam int RR  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [IDW-1:0] ar_id    [2];
    logic [AW-1:0]  ar_addr  [2];
    logic [LW-1:0]  ar_len   [2];
    logic [SW-1:0]  ar_size  [2];
    logic [1:0]     ar_burst [2];
    logic           ar_valid [2];
    logic           ar_ready [2];
    logic           r_ready  [2];
    logic [IDW-1:0] r_id     [2];
    logic [DW-1:0]  r_data   [2];
    logic [1:0]     r_resp   [2];
    logic           r_last   [2];
    logic           r_valid  [2];

    logic [IDW-1:0] s_arid;
    logic [AW-1:0]  s_araddr;
    logic [LW-1:0]  s_arlen;
    logic [SW-1:0]  s_arsize;
    logic [1:0]     s_arburst;
    logic           s_arvalid;
    logic           s_arready;
    logic [IDW-1:0] s_rid;
    logic [DW-1:0]  s_rdata;
    logic [1:0]     s_rresp;
    logic           s_rlast;
    logic           s_rvalid;
    logic           s_rready;
    logic [1:0]     grant;

    axi_rd_arbiter #(.RR_INIT(RR)) dut (
        .AXI_CLK_i    (clk),
        .AXI_RST_i    (rst_n),
        .M0_ARID_i    (ar_id[0]),
        .M0_ARADDR_i  (ar_addr[0]),
        .M0_ARLEN_i   (ar_len[0]),
        .M0_ARSIZE_i  (ar_size[0]),
        .M0_ARBURST_i (ar_burst[0]),
        .M0_ARVALID_i (ar_valid[0]),
        .M0_ARREADY_o (ar_ready[0]),
        .M0_RID_o     (r_id[0]),
        .M0_RDATA_o   (r_data[0]),
        .M0_RRESP_o   (r_resp[0]),
        .M0_RLAST_o   (r_last[0]),
        .M0_RVALID_o  (r_valid[0]),
        .M0_RREADY_i  (r_ready[0]),
        .M1_ARID_i    (ar_id[1]),
        .M1_ARADDR_i  (ar_addr[1]),
        .M1_ARLEN_i   (ar_len[1]),
        .M1_ARSIZE_i  (ar_size[1]),
        .M1_ARBURST_i (ar_burst[1]),
        .M1_ARVALID_i (ar_valid[1]),
        .M1_ARREADY_o (ar_ready[1]),
        .M1_RID_o     (r_id[1]),
        .M1_RDATA_o   (r_data[1]),
        .M1_RRESP_o   (r_resp[1]),
        .M1_RLAST_o   (r_last[1]),
        .M1_RVALID_o  (r_valid[1]),
        .M1_RREADY_i  (r_ready[1]),
        .S_ARID_o     (s_arid),
        .S_ARADDR_o   (s_araddr),
        .S_ARLEN_o    (s_arlen),
        .S_ARSIZE_o   (s_arsize),
        .S_ARBURST_o  (s_arburst),
        .S_ARVALID_o  (s_arvalid),
        .S_ARREADY_i  (s_arready),
        .S_RID_i      (s_rid),
        .S_RDATA_i    (s_rdata),
        .S_RRESP_i    (s_rresp),
        .S_RLAST_i    (s_rlast),
        .S_RVALID_i   (s_rvalid),
        .S_RREADY_o   (s_rready),
        .GRANT_o      (grant)
    );

    // Reference model: who owns the slave (-1 = nobody), whether the address
    // has been accepted yet, and which master wins a tie.
    int owner;
    bit addr_pending;
    int prio;

    int vectors;
    int miscompares;
    logic [DW-1:0] rx0[$];
    logic [DW-1:0] rx1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int  o;
        bit  ea;
        bit  ed;
        #1;
        o  = (owner < 0) ? 0 : owner;
        ea = (owner >= 0) && addr_pending;
        ed = (owner >= 0) && !addr_pending;
        chk("grant", 64'(grant), (owner < 0) ? 64'd0 : 64'(1 << owner));
        chk("s_arvalid", 64'(s_arvalid), 64'(ea));
        chk("s_ar_payload", 64'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}),
            ea ? 64'({ar_id[o], ar_addr[o], ar_len[o], ar_size[o], ar_burst[o]}) : 64'd0);
        chk("s_rready", 64'(s_rready), ed ? 64'(r_ready[o]) : 64'd0);
        for (int m = 0; m < 2; m++) begin
            chk(m ? "m1_arready" : "m0_arready", 64'(ar_ready[m]),
                (ea && m == owner) ? 64'(s_arready) : 64'd0);
            chk(m ? "m1_r_bundle" : "m0_r_bundle",
                64'({r_valid[m], r_id[m], r_data[m], r_resp[m], r_last[m]}),
                (ed && m == owner) ? 64'({s_rvalid, s_rid, s_rdata, s_rresp, s_rlast}) : 64'd0);
        end
        if (r_valid[0] && r_ready[0]) rx0.push_back(r_data[0]);
        if (r_valid[1] && r_ready[1]) rx1.push_back(r_data[1]);
        @(posedge clk);
        if (!rst_n) begin
            owner = -1;
            addr_pending = 1'b0;
            prio = RR;
        end else if (owner < 0) begin
            if (ar_valid[0] || ar_valid[1]) begin
                owner = (ar_valid[0] && ar_valid[1]) ? prio : (ar_valid[0] ? 0 : 1);
                addr_pending = 1'b1;
            end
        end else if (addr_pending) begin
            if (s_arready) addr_pending = 1'b0;
        end else if (s_rvalid && r_ready[owner] && s_rlast) begin
            prio  = 1 - owner;
            owner = -1;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int m, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        ar_id[m]    = IDW'($urandom);
        ar_addr[m]  = addr;
        ar_len[m]   = len;
        ar_size[m]  = 3'd2;
        ar_burst[m] = 2'b01;
        ar_valid[m] = 1'b1;
    endtask

    task automatic addr_phase(input int stall);
        int o;
        o = (owner < 0) ? 0 : owner;
        s_arready = 1'b0;
        repeat (stall) cycle();
        s_arready = 1'b1;
        cycle();
        s_arready = 1'b0;
        ar_valid[o] = 1'b0;
    endtask

    task automatic data_phase(input int beats, input bit toggle, input logic [DW-1:0] base);
        int k;
        int guard;
        int o;
        bit tg;
        k = 0;
        guard = 0;
        tg = 1'b1;
        o = (owner < 0) ? 0 : owner;
        while (k < beats && guard < 64) begin
            s_rvalid   = 1'b1;
            s_rdata    = base + DW'(k);
            s_rlast    = (k == beats - 1);
            s_rid      = IDW'($urandom);
            s_rresp    = 2'($urandom);
            r_ready[o] = toggle ? tg : 1'b1;
            r_ready[1 - o] = 1'b1;
            tg = ~tg;
            if (r_ready[o]) k++;
            cycle();
            guard++;
        end
        chk("data_budget", 64'(k), 64'(beats));
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        r_ready[0] = 1'b0;
        r_ready[1] = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            ar_id[m] = '0; ar_addr[m] = '0; ar_len[m] = '0; ar_size[m] = '0;
            ar_burst[m] = '0; ar_valid[m] = 1'b0; r_ready[m] = 1'b0;
        end
        s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0;
        s_rlast = 1'b0; s_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        owner = -1;
        addr_pending = 1'b0;
        prio = RR;
        rst_n = 1'b1;

        // Reset state, then a single 4-beat M0 burst
        cycle();
        set_req(0, 32'h1000, 8'd3);
        cycle();
        addr_phase(0);
        data_phase(4, 1'b0, 32'h10);
        cycle();
        chk("m0_beats", 64'(rx0.size()), 64'd4);
        chk("m1_beats", 64'(rx1.size()), 64'd0);

        // Simultaneous requests alternate, starting from RR_INIT
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        set_req(0, 32'h2000, 8'd1);
        set_req(1, 32'h3000, 8'd1);
        cycle();
        chk("tie_first", 64'(grant), 64'd1);
        addr_phase(0);
        data_phase(2, 1'b0, 32'h20);
        cycle();
        chk("tie_second", 64'(grant), 64'd2);
        addr_phase(5);
        set_req(0, 32'h4000, 8'd0);
        data_phase(2, 1'b0, 32'h30);
        set_req(1, 32'h5000, 8'd0);
        cycle();
        chk("alternate_m0", 64'(grant), 64'd1);
        addr_phase(0);
        data_phase(1, 1'b0, 32'h40);
        cycle();
        chk("alternate_m1", 64'(grant), 64'd2);
        addr_phase(0);
        rx1.delete();
        data_phase(4, 1'b1, 32'hA0);
        chk("toggle_count", 64'(rx1.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("toggle_order", (i < rx1.size()) ? 64'(rx1[i]) : 64'hDEAD, 64'(32'hA0 + i));

        // Reset mid-burst restores priority to RR_INIT
        set_req(0, 32'h6000, 8'd0);
        cycle();
        addr_phase(0);
        data_phase(1, 1'b0, 32'h50);
        set_req(0, 32'h7000, 8'd3);
        cycle();
        addr_phase(0);
        s_rvalid = 1'b1; s_rdata = 32'h60; r_ready[0] = 1'b1;
        cycle();
        s_rdata = 32'h61; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; s_rvalid = 1'b0; r_ready[0] = 1'b0; ar_valid[0] = 1'b0;
        cycle();
        chk("reset_grant", 64'(grant), 64'd0);
        set_req(0, 32'h8000, 8'd0);
        set_req(1, 32'h9000, 8'd0);
        cycle();
        chk("prio_restored", 64'(grant), 64'd1);
        addr_phase(0);
        data_phase(1, 1'b0, 32'h70);
        cycle();
        chk("m1_after_reset", 64'(grant), 64'd2);
        addr_phase(0);
        data_phase(1, 1'b0, 32'h80);

        // Spurious read data while idle
        s_rvalid = 1'b1; s_rlast = 1'b1; r_ready[0] = 1'b1; r_ready[1] = 1'b1;
        repeat (3) cycle();
        chk("spurious_idle", 64'(grant), 64'd0);
        s_rvalid = 1'b0; s_rlast = 1'b0; r_ready[0] = 1'b0; r_ready[1] = 1'b0;
        cycle();

        // Randomized traffic
        repeat (600) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int m = 0; m < 2; m++) begin
                ar_id[m]    = IDW'($urandom);
                ar_addr[m]  = AW'($urandom);
                ar_len[m]   = LW'($urandom);
                ar_size[m]  = SW'($urandom);
                ar_burst[m] = 2'($urandom);
                ar_valid[m] = 1'($urandom_range(0, 1));
                r_ready[m]  = 1'($urandom_range(0, 1));
            end
            s_arready = 1'($urandom_range(0, 1));
            s_rid     = IDW'($urandom);
            s_rdata   = DW'($urandom);
            s_rresp   = 2'($urandom);
            s_rvalid  = 1'($urandom_range(0, 1));
            s_rlast   = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
